// File: rtl/rnd_gen_pkg.sv
// Shared constants and types for the rnd_gen LFSR front end.
// Optional wrap detection is enabled by defining RND_WRAP_EN.
package rnd_gen_pkg;

  localparam int RND_W = 8;
  localparam logic [RND_W-1:0] RND_SEED_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    RND_S_INIT = 2'd0,
    RND_S_FILL = 2'd1,
    RND_S_FULL = 2'd2
  } rnd_state_e;

  // All-zero is the LFSR lock-up state, so a zero seed falls back to the default.
  function automatic logic [RND_W-1:0] rnd_seed_guard(input logic [RND_W-1:0] seed,
                                                      input logic [RND_W-1:0] dflt);
    return (seed == '0) ? dflt : seed;
  endfunction

endpackage

// File: rtl/rnd_gen_random.sv
// Combinational LFSR step, taps 8,6,5,4 (maximal length, period 255).
module rnd_gen_random
  import rnd_gen_pkg::*;
(
  input  logic [RND_W-1:0] in_i,
  output logic [RND_W-1:0] rnd_out_o
);

  assign rnd_out_o = {in_i[6:0], in_i[7] ^ in_i[5] ^ in_i[4] ^ in_i[3]};

endmodule

// File: rtl/rnd_gen.sv
// LFSR state register with a show-ahead prefetch buffer and valid/rd_en pop port.
// Define RND_WRAP_EN to add the `wrap` output flagging a return to the seed value.
module rnd_gen
  import rnd_gen_pkg::*;
#(
  parameter int               DEPTH = 4,
  parameter logic [RND_W-1:0] SEED  = RND_SEED_DEFAULT,
  localparam int              PW    = $clog2(DEPTH),
  localparam int              CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [RND_W-1:0] seed_in,
  input  logic             rd_en,
  output logic [RND_W-1:0] rnd_data,
  output logic             rnd_valid,
  output logic [CW-1:0]    count
`ifdef RND_WRAP_EN
  ,
  output logic             wrap
`endif
);

  rnd_state_e       state_q, state_d;
  logic [RND_W-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic [RND_W-1:0] mem_q [DEPTH];

  rnd_gen_random u_random (
    .in_i      (lfsr_q),
    .rnd_out_o (lfsr_next)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = rd_en && (count_q != '0) && !seed_we;
    if (seed_we) begin
      lfsr_d   = rnd_seed_guard(seed_in, SEED);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = RND_S_INIT;
    end else begin
      case (state_q)
        RND_S_INIT: push = 1'b0;
        RND_S_FILL: push = 1'b1;
        RND_S_FULL: push = pop;  // only refill the slot a pop just freed
        default:    push = 1'b0;
      endcase
      if (push) begin
        lfsr_d   = lfsr_next;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (state_q == RND_S_INIT) begin
        state_d = RND_S_FILL;
      end else begin
        state_d = (count_d == CW'(DEPTH)) ? RND_S_FULL : RND_S_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RND_S_INIT;
      lfsr_q   <= SEED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= lfsr_next;
    end
  end

  assign rnd_valid = (count_q != '0);
  assign rnd_data  = rnd_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

`ifdef RND_WRAP_EN
  logic [RND_W-1:0] origin_q;
  logic             wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_q <= SEED;
      wrap_q   <= 1'b0;
    end else if (seed_we) begin
      origin_q <= rnd_seed_guard(seed_in, SEED);
      wrap_q   <= 1'b0;
    end else begin
      wrap_q   <= push && (lfsr_next == origin_q);
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_rnd_gen.sv
// Self-checking bench for rnd_gen: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_rnd_gen;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          seed_we = 1'b0;
  logic [7:0]    seed_in = 8'h00;
  logic          rd_en   = 1'b0;
  logic [7:0]    rnd_data;
  logic          rnd_valid;
  logic [CW-1:0] count;
`ifdef RND_WRAP_EN
  logic          wrap;
`endif

  rnd_gen #(.DEPTH(DEPTH), .SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_we   (seed_we),
    .seed_in   (seed_in),
    .rd_en     (rd_en),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .count     (count)
`ifdef RND_WRAP_EN
    ,
    .wrap      (wrap)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO kept as full as possible, refilled from the LFSR sequence.
  logic [7:0] mq[$];
  logic [7:0] m_state;
  logic [7:0] m_origin;
  bit         m_init;
  bit         m_wrap;
  int         m_gen;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [7:0] m_head();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_reset();
    m_state  = 8'hA5;
    m_origin = 8'hA5;
    mq.delete();
    m_init   = 1'b1;
    m_wrap   = 1'b0;
    m_gen    = 0;
  endtask

  task automatic model_clock(input logic we, input logic [7:0] s, input logic rd);
    m_wrap = 1'b0;
    if (we) begin
      m_state  = (s == 8'h00) ? 8'hA5 : s;
      m_origin = m_state;
      mq.delete();
      m_init   = 1'b1;
      m_gen    = 0;
    end else begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (m_init) begin
        m_init = 1'b0;
      end else if (mq.size() < DEPTH) begin
        m_state = lfsr_step(m_state);
        mq.push_back(m_state);
        m_gen  = m_gen + 1;
        m_wrap = (m_state == m_origin);
      end
    end
  endtask

  task automatic drive_cycle(input logic we, input logic [7:0] s, input logic rd);
    seed_we = we;
    seed_in = s;
    rd_en   = rd;
    @(posedge clk);
    model_clock(we, s, rd);
    #1;
    $display("[%0t] we=%0b seed=%h rd=%0b -> valid=%0b data=%h count=%0d",
             $time, we, s, rd, rnd_valid, rnd_data, count);
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    seed_we = 1'b0;
    rd_en   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
    checks++;
    if (rnd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rnd_data); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL fill_init_valid: got %b expected 0", rnd_valid); end
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h4A || count !== CW'(1)) begin
      errors++;
      $display("FAIL fill_first: got valid=%b data=%h count=%0d expected 1/4A/1", rnd_valid, rnd_data, count);
    end
    repeat (5) drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== CW'(DEPTH) || rnd_data !== 8'h4A) begin
      errors++;
      $display("FAIL fill_full: got count=%0d data=%h expected %0d/4A", count, rnd_data, DEPTH);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_seq [6] = '{8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rnd_data !== exp_seq[i] || count !== CW'(DEPTH)) begin
        errors++;
        $display("FAIL stream_%0d: got data=%h count=%0d expected %h/%0d", i, rnd_data, count, exp_seq[i], DEPTH);
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_empty_pop();
    apply_reset();
    drive_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (count !== '0 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop: got count=%0d valid=%b expected 0/0", count, rnd_valid);
    end
    drive_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (count !== CW'(1) || rnd_data !== 8'h4A) begin
      errors++;
      $display("FAIL empty_pop_first: got count=%0d data=%h expected 1/4A", count, rnd_data);
    end
  endtask

  task automatic test_seed_zero();
    repeat (4) drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== CW'(DEPTH)) begin errors++; $display("FAIL seed0_prefull: got %0d expected %0d", count, DEPTH); end
    drive_cycle(1'b1, 8'h00, 1'b1);
    checks++;
    if (count !== '0 || rnd_valid !== 1'b0 || rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL seed0_flush: got count=%0d valid=%b data=%h expected 0/0/00", count, rnd_valid, rnd_data);
    end
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (count !== '0) begin errors++; $display("FAIL seed0_init: got count=%0d expected 0", count); end
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rnd_data !== 8'h4A || count !== CW'(1)) begin
      errors++;
      $display("FAIL seed0_first: got data=%h count=%0d expected 4A/1", rnd_data, count);
    end
  endtask

  task automatic test_seed_nonzero();
    drive_cycle(1'b1, 8'h4A, 1'b0);
    drive_cycle(1'b1, 8'h4A, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("FAIL seed_b2b_init: got valid=%b expected 0", rnd_valid); end
    drive_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rnd_data !== 8'h95 || count !== CW'(1)) begin
      errors++;
      $display("FAIL seed4A_first: got data=%h count=%0d expected 95/1", rnd_data, count);
    end
    drive_cycle(1'b0, 8'h00, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || rnd_valid !== 1'b0 || rnd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got count=%0d valid=%b data=%h expected 0/0/00", count, rnd_valid, rnd_data);
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic       we, rd;
    logic [7:0] s;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      we = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 9) < 6);
      s  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive_cycle(we, s, rd);
      checks++;
      if (count !== CW'(mq.size()) || rnd_valid !== (mq.size() > 0) || rnd_data !== m_head()) begin
        errors++;
        $display("FAIL random_%0d: got count=%0d valid=%b data=%h expected %0d/%b/%h",
                 i, count, rnd_valid, rnd_data, mq.size(), (mq.size() > 0), m_head());
      end
`ifdef RND_WRAP_EN
      checks++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL random_wrap_%0d: got %b expected %b", i, wrap, m_wrap); end
`endif
    end
  endtask

`ifdef RND_WRAP_EN
  task automatic test_wrap();
    int pulses    = 0;
    int first_gen = -1;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (wrap !== m_wrap) begin errors++; $display("FAIL wrap_%0d: got %b expected %b", i, wrap, m_wrap); end
      if (wrap === 1'b1) begin
        pulses++;
        if (first_gen < 0) first_gen = m_gen;
      end
    end
    checks++;
    if (pulses != 2 || first_gen != 255) begin
      errors++;
      $display("FAIL wrap_period: got pulses=%0d first=%0d expected 2/255", pulses, first_gen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_empty_pop();
    test_seed_zero();
    test_seed_nonzero();
    test_random();
`ifdef RND_WRAP_EN
    test_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
